// File: rtl/collision_pkg.sv
// Shared definitions for the collision arbiter: direction codes, FSM states,
// probe-point selectors and the edge geometry constants.
// Optional feature macro: COLL_TWO_POINT_EN (two corner probes per check).
package collision_pkg;

    // Requested step direction
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Distance of the probe beyond the sprite edge, and corner inset along it
    localparam int EDGE_GAP     = 3;
    localparam int CORNER_INSET = 4;

    // Which point along the leading edge the probe generator produces
    localparam logic [1:0] PT_CENTRE = 2'd0;
    localparam logic [1:0] PT_NEAR   = 2'd1;
    localparam logic [1:0] PT_FAR    = 2'd2;

    // Arbiter FSM states; PROBE_B only exists in the two-point build
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROBE_A = 2'd1,
        ST_DONE    = 2'd2
`ifdef COLL_TWO_POINT_EN
        ,
        ST_PROBE_B = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/collision_arbiter_probe_point_gen.sv
// Combinational probe point generator: maps a sprite's top-left corner,
// step direction and point selector onto the map coordinate just beyond
// its leading edge. All arithmetic wraps (10-bit X, 9-bit Y); the map
// treats wrapped, out-of-field coordinates as walls.
module probe_point_gen
    import collision_pkg::*;
#(
    parameter int SPRITE = 32
) (
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic [1:0] i_dir,
    input  logic [1:0] i_point_sel,
    output logic [9:0] o_px,
    output logic [8:0] o_py
);

    localparam logic [9:0] OFF_CENTRE = 10'(SPRITE / 2);
    localparam logic [9:0] OFF_NEAR   = 10'(CORNER_INSET);
    localparam logic [9:0] OFF_FAR    = 10'(SPRITE - CORNER_INSET);
    localparam logic [9:0] GAP_X      = 10'(EDGE_GAP);
    localparam logic [8:0] GAP_Y      = 9'(EDGE_GAP);
    localparam logic [9:0] BEYOND_X   = 10'(SPRITE + EDGE_GAP);
    localparam logic [8:0] BEYOND_Y   = 9'(SPRITE + EDGE_GAP);

    logic [9:0] w_off;

    // Offset along the leading edge for the selected point
    always_comb begin
        w_off = OFF_CENTRE;
        case (i_point_sel)
            PT_NEAR: w_off = OFF_NEAR;
            PT_FAR:  w_off = OFF_FAR;
            default: w_off = OFF_CENTRE;
        endcase
    end

    // Place the probe just outside the edge the sprite is moving towards
    always_comb begin
        o_px = i_x + w_off;
        o_py = i_y - GAP_Y;
        case (i_dir)
            DIR_UP: begin
                o_px = i_x + w_off;
                o_py = i_y - GAP_Y;
            end
            DIR_DOWN: begin
                o_px = i_x + w_off;
                o_py = i_y + BEYOND_Y;
            end
            DIR_LEFT: begin
                o_px = i_x - GAP_X;
                o_py = i_y + w_off[8:0];
            end
            default: begin
                o_px = i_x + BEYOND_X;
                o_py = i_y + w_off[8:0];
            end
        endcase
    end

endmodule

// File: rtl/collision_arbiter.sv
// Round-robin collision arbiter: serialises "may I step?" checks from all
// sprite movers onto one combinational wall-map port and returns a
// registered clear/blocked verdict plus a one-cycle done pulse per mover.
// Optional feature macro: COLL_TWO_POINT_EN (probe both leading-edge corners
// instead of the edge centre; adds the PROBE_B state, one extra cycle).
module collision_arbiter
    import collision_pkg::*;
#(
    parameter int NREQ   = 5,
    parameter int SPRITE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*10-1:0] req_x,
    input  logic [NREQ*9-1:0] req_y,
    input  logic [NREQ*2-1:0] req_dir,
    output logic [9:0]        map_x,
    output logic [8:0]        map_y,
    input  logic              map_is_wall,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   clear,
    output logic              busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

`ifdef COLL_TWO_POINT_EN
    localparam logic [1:0] PT_FIRST  = PT_NEAR;
    localparam logic [1:0] PT_SECOND = PT_FAR;
`else
    localparam logic [1:0] PT_FIRST  = PT_CENTRE;
    localparam logic [1:0] PT_SECOND = PT_CENTRE;
`endif

    state_t r_state;
    state_t w_state_next;

    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] r_gnt;
    logic [9:0]       r_x;
    logic [8:0]       r_y;
    logic [1:0]       r_dir;
    logic [9:0]       r_map_x;
    logic [8:0]       r_map_y;
    logic [NREQ-1:0]  r_done;
    logic [NREQ-1:0]  r_clear;
`ifdef COLL_TWO_POINT_EN
    logic             r_wall_acc;
    logic             w_load_b;
`endif

    logic [9:0]       w_x_arr   [NREQ];
    logic [8:0]       w_y_arr   [NREQ];
    logic [1:0]       w_dir_arr [NREQ];
    logic [NREQ-1:0]  w_gnt_onehot;
    logic             w_any;
    logic             w_found;
    int               w_rr_idx;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_load_a;
    logic             w_finish;
    logic             w_wall_final;
    logic [9:0]       w_pg_x;
    logic [8:0]       w_pg_y;
    logic [1:0]       w_pg_dir;
    logic [1:0]       w_pg_sel;
    logic [9:0]       w_px;
    logic [8:0]       w_py;

    // Unpack the per-requester coordinate buses and decode the latched grant
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_x_arr[gi]      = req_x[10*gi +: 10];
        assign w_y_arr[gi]      = req_y[9*gi +: 9];
        assign w_dir_arr[gi]    = req_dir[2*gi +: 2];
        assign w_gnt_onehot[gi] = (r_gnt == IDX_W'(gi));
    end

    // Round-robin pick: first active request above the last grant, wrapping
    always_comb begin
        w_any     = |req;
        w_found   = 1'b0;
        w_rr_idx  = 0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_rr_idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_found && req[w_rr_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDX_W'(w_rr_idx);
            end
        end
    end

    // Probe generator input: the live winner while granting, the latched
    // request afterwards so late input changes never reach an open check
    always_comb begin
        w_pg_x   = r_x;
        w_pg_y   = r_y;
        w_pg_dir = r_dir;
        w_pg_sel = PT_SECOND;
        if (r_state == ST_IDLE) begin
            w_pg_x   = w_x_arr[w_gnt_idx];
            w_pg_y   = w_y_arr[w_gnt_idx];
            w_pg_dir = w_dir_arr[w_gnt_idx];
            w_pg_sel = PT_FIRST;
        end
    end

    probe_point_gen #(
        .SPRITE (SPRITE)
    ) u_probe (
        .i_x         (w_pg_x),
        .i_y         (w_pg_y),
        .i_dir       (w_pg_dir),
        .i_point_sel (w_pg_sel),
        .o_px        (w_px),
        .o_py        (w_py)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-state control strobes
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_finish     = 1'b0;
        w_wall_final = map_is_wall;
`ifdef COLL_TWO_POINT_EN
        w_load_b     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_load_a     = 1'b1;
                    w_state_next = ST_PROBE_A;
                end
            end
            ST_PROBE_A: begin
`ifdef COLL_TWO_POINT_EN
                w_load_b     = 1'b1;
                w_state_next = ST_PROBE_B;
`else
                w_finish     = 1'b1;
                w_state_next = ST_DONE;
`endif
            end
`ifdef COLL_TWO_POINT_EN
            ST_PROBE_B: begin
                w_wall_final = r_wall_acc | map_is_wall;
                w_finish     = 1'b1;
                w_state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Grant latch, probe register and verdict outputs; the verdict is
    // registered on the last probe cycle so it is visible in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= LAST_IDX;
            r_gnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_dir        <= '0;
            r_map_x      <= '0;
            r_map_y      <= '0;
            r_done       <= '0;
            r_clear      <= '0;
`ifdef COLL_TWO_POINT_EN
            r_wall_acc   <= 1'b0;
`endif
        end else begin
            r_done <= w_finish ? w_gnt_onehot : '0;
            if (w_load_a) begin
                r_gnt   <= w_gnt_idx;
                r_x     <= w_x_arr[w_gnt_idx];
                r_y     <= w_y_arr[w_gnt_idx];
                r_dir   <= w_dir_arr[w_gnt_idx];
                r_map_x <= w_px;
                r_map_y <= w_py;
            end
`ifdef COLL_TWO_POINT_EN
            if (w_load_b) begin
                r_wall_acc <= map_is_wall;
                r_map_x    <= w_px;
                r_map_y    <= w_py;
            end
`endif
            if (w_finish) begin
                r_clear <= (r_clear & ~w_gnt_onehot)
                         | ({NREQ{~w_wall_final}} & w_gnt_onehot);
            end
            if (r_state == ST_DONE) begin
                r_last_grant <= r_gnt;
            end
        end
    end

    assign map_x = r_map_x;
    assign map_y = r_map_y;
    assign done  = r_done;
    assign clear = r_clear;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter (default single-point build): table of
// single-requester checks against a small wall map, plus sequences for
// round-robin fairness and reset in the middle of a check.
module tb_collision_arbiter;

    localparam int NREQ = 5;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*10-1:0] req_x;
    logic [NREQ*9-1:0] req_y;
    logic [NREQ*2-1:0] req_dir;
    logic [9:0]        map_x;
    logic [8:0]        map_y;
    logic              map_is_wall;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   clear;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         idx;
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] dir;
        logic [9:0] px;
        logic [8:0] py;
        logic       clr;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0] done;
        logic [NREQ-1:0] clear;
    } sb_t;

    sb_t             sb_q[$];
    logic [NREQ-1:0] exp_clear;
    vec_t            vt[8];

    collision_arbiter #(.NREQ(NREQ), .SPRITE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_dir     (req_dir),
        .map_x       (map_x),
        .map_y       (map_y),
        .map_is_wall (map_is_wall),
        .done        (done),
        .clear       (clear),
        .busy        (busy)
    );

    // 640x480 field; anything outside is wall, plus two wall tiles
    function automatic logic is_wall(input logic [9:0] x, input logic [8:0] y);
        if (x >= 10'd640 || y >= 9'd480) return 1'b1;
        if (x == 10'd80 && y == 9'd61) return 1'b1;
        if (x == 10'd297 && y == 9'd116) return 1'b1;
        return 1'b0;
    endfunction

    assign map_is_wall = is_wall(map_x, map_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the next expected one
    always @(negedge clk) begin
        if (rst && done != '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%b required=none", done);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                $display("txn done=%b clear=%b (exp done=%b clear=%b)", done, clear, e.done, e.clear);
                checks++;
                if (done !== e.done) begin
                    errors++;
                    $display("FAIL done_vec actual=%b required=%b", done, e.done);
                end
                checks++;
                if (clear !== e.clear) begin
                    errors++;
                    $display("FAIL clear_vec actual=%b required=%b", clear, e.clear);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [9:0] x, input logic [8:0] y, input logic [1:0] d);
        req_x[10*i +: 10] = x;
        req_y[9*i +: 9]   = y;
        req_dir[2*i +: 2] = d;
    endtask

    task automatic push_exp(input int i);
        sb_t e;
        e.done    = '0;
        e.done[i] = 1'b1;
        e.clear   = exp_clear;
        sb_q.push_back(e);
    endtask

    task automatic wait_sb_empty(input string name);
        for (int w = 0; w < 12 && sb_q.size() != 0; w++) begin
            @(negedge clk);
            #1;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb_q.delete();
        exp_clear = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        req       = '0;
        req_x     = '0;
        req_y     = '0;
        req_dir   = '0;
        exp_clear = '0;

        //              idx  x        y       dir    px        py      clr
        vt[0] = '{0, 10'd100, 9'd200, 2'b11, 10'd135,  9'd216, 1'b1};
        vt[1] = '{2, 10'd64,  9'd64,  2'b00, 10'd80,   9'd61,  1'b0};
        vt[2] = '{1, 10'd1,   9'd100, 2'b10, 10'd1022, 9'd116, 1'b0};
        vt[3] = '{3, 10'd200, 9'd300, 2'b01, 10'd216,  9'd335, 1'b1};
        vt[4] = '{4, 10'd300, 9'd100, 2'b10, 10'd297,  9'd116, 1'b0};
        vt[5] = '{0, 10'd600, 9'd50,  2'b11, 10'd635,  9'd66,  1'b1};
        vt[6] = '{1, 10'd10,  9'd1,   2'b00, 10'd26,   9'd510, 1'b0};
        vt[7] = '{2, 10'd600, 9'd440, 2'b01, 10'd616,  9'd475, 1'b1};

        do_reset();
        @(negedge clk);
        chk("rst_clear", 32'(clear), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_map_x", 32'(map_x), 32'd0);
        chk("rst_map_y", 32'(map_y), 32'd0);

        // Table of single-requester checks
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = '0;
            req[vt[i].idx] = 1'b1;
            set_req(vt[i].idx, vt[i].x, vt[i].y, vt[i].dir);
            exp_clear[vt[i].idx] = vt[i].clr;
            push_exp(vt[i].idx);
            @(posedge clk);
            #1;
            req_x[10*vt[i].idx +: 10] = ~vt[i].x;
            chk($sformatf("v%0d_map_x", i), 32'(map_x), 32'(vt[i].px));
            chk($sformatf("v%0d_map_y", i), 32'(map_y), 32'(vt[i].py));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_sb_empty($sformatf("v%0d_done_seen", i));
            req = '0;
        end

        // Fairness: all requesters held, order 0,1,2,3,4,0 three cycles apart
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 10'd100, 9'd200, 2'b11);
        req = '1;
        for (int k = 0; k < 6; k++) begin
            exp_clear[k % NREQ] = 1'b1;
            push_exp(k % NREQ);
        end
        begin
            int last_cyc;
            last_cyc = 0;
            for (int k = 0; k < 6; k++) begin
                bit seen;
                seen = 1'b0;
                for (int w = 0; w < 10 && !seen; w++) begin
                    @(negedge clk);
                    #1;
                    if (done != '0) seen = 1'b1;
                end
                if (!seen) begin
                    checks++;
                    errors++;
                    $display("FAIL fair_timeout actual=no_done required=done_%0d", k);
                end else if (k > 0) begin
                    chk($sformatf("fair_gap%0d", k), 32'(cyc - last_cyc), 32'd3);
                end
                last_cyc = cyc;
            end
        end
        req = '0;
        wait_sb_empty("fair_all_done");

        // Reset during PROBE_A: no done, back to IDLE, requester 0 wins first
        @(negedge clk);
        set_req(0, 10'd100, 9'd200, 2'b11);
        set_req(1, 10'd300, 9'd100, 2'b10);
        req = 5'b00011;
        @(posedge clk);
        #1;
        chk("mid_grant1_map_x", 32'(map_x), 32'd297);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_done",  32'(done),  32'd0);
        chk("mid_rst_map_x", 32'(map_x), 32'd0);
        chk("mid_rst_clear", 32'(clear), 32'd0);
        sb_q.delete();
        exp_clear = '0;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_done", 32'(done), 32'd0);
        exp_clear[0] = 1'b1;
        push_exp(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_after_map_x", 32'(map_x), 32'd135);
        chk("mid_after_map_y", 32'(map_y), 32'd216);
        wait_sb_empty("mid_after_done");
        req = '0;
        repeat (3) @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
